// File: rtl/processor_core_pkg.sv
// Shared types, default widths and saturating arithmetic for the neuron processor core.
package processor_core_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam int NUM_NEURONS_DEF = 8;
    localparam int POT_W_DEF       = 8;
    localparam int W_W_DEF         = 4;
    localparam int THR_RESET_DEF   = 16;

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic int sat_add(input int a, input int b, input int w);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (w - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/processor_core.sv
// Integrate-and-fire neuron core: accumulates weighted tokens, then scans
// all neurons on tock and emits one output token per neuron at threshold.
module processor_core
    import processor_core_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int POT_W       = POT_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int THR_RESET   = THR_RESET_DEF,
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tok_in_valid,
    output logic                    tok_in_ready,
    input  logic [IDX_W-1:0]        tok_in_idx,
    input  logic signed [W_W-1:0]   tok_in_weight,
    input  logic                    tock,
    output logic                    tok_out_valid,
    input  logic                    tok_out_ready,
    output logic [IDX_W-1:0]        tok_out_idx,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_addr,
    input  logic signed [POT_W-1:0] cfg_data,
    output logic                    busy,
    output logic                    done
);

    logic signed [POT_W-1:0] pot [NUM_NEURONS];
    logic signed [POT_W-1:0] thr [NUM_NEURONS];
    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic                    fire;
    logic                    last;
    logic                    advance;
    logic                    accept_in;
    logic signed [POT_W-1:0] pot_sum;

    always_comb begin
        fire      = (state == EMIT) && (pot[ptr] >= thr[ptr]);
        last      = (ptr == IDX_W'(NUM_NEURONS - 1));
        advance   = (state == EMIT) && (!fire || tok_out_ready);
        accept_in = (state == ACCUM) && tok_in_valid;
        pot_sum   = POT_W'(sat_add(int'(pot[tok_in_idx]), int'(tok_in_weight), POT_W));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (tock) state_nxt = EMIT;
            EMIT:    if (advance && last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            ptr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == EMIT);
            done  <= advance && last;
            if ((state == ACCUM) && tock) begin
                ptr <= '0;
            end else if (advance) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Input integration and fire-clear never coincide: they belong to different states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot[i] <= '0;
                thr[i] <= POT_W'(THR_RESET);
            end
        end else begin
            if (accept_in) begin
                pot[tok_in_idx] <= pot_sum;
            end else if (fire && tok_out_ready) begin
                pot[ptr] <= '0;
            end
            if (cfg_we) begin
                thr[cfg_addr] <= cfg_data;
            end
        end
    end

    always_comb begin
        tok_in_ready  = (state == ACCUM);
        tok_out_valid = fire;
        tok_out_idx   = ptr;
    end

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core with a token scoreboard.
module tb_processor_core;

    localparam int N  = 8;
    localparam int PW = 8;
    localparam int WW = 4;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 tok_in_valid;
    logic                 tok_in_ready;
    logic [IW-1:0]        tok_in_idx;
    logic signed [WW-1:0] tok_in_weight;
    logic                 tock;
    logic                 tok_out_valid;
    logic                 tok_out_ready;
    logic [IW-1:0]        tok_out_idx;
    logic                 cfg_we;
    logic [IW-1:0]        cfg_addr;
    logic signed [PW-1:0] cfg_data;
    logic                 busy;
    logic                 done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int obs_q[$];

    always #5 clk = ~clk;

    processor_core #(
        .NUM_NEURONS(N),
        .POT_W(PW),
        .W_W(WW),
        .THR_RESET(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tok_in_valid(tok_in_valid),
        .tok_in_ready(tok_in_ready),
        .tok_in_idx(tok_in_idx),
        .tok_in_weight(tok_in_weight),
        .tock(tock),
        .tok_out_valid(tok_out_valid),
        .tok_out_ready(tok_out_ready),
        .tok_out_idx(tok_out_idx),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .busy(busy),
        .done(done)
    );

    // Accepted output tokens are collected here for the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tok_out_valid && tok_out_ready) begin
            obs_q.push_back(int'(tok_out_idx));
        end
    end

    task automatic send_tok(input logic [IW-1:0] idx, input logic signed [WW-1:0] w);
        @(posedge clk); #1;
        tok_in_valid  = 1'b1;
        tok_in_idx    = idx;
        tok_in_weight = w;
        @(posedge clk); #1;
        tok_in_valid  = 1'b0;
    endtask

    task automatic cfg_write(input logic [IW-1:0] addr, input logic signed [PW-1:0] data);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic run_scan(input bit tv, input logic [IW-1:0] ti, input logic signed [WW-1:0] tw,
                            output int bc, output bit dn, output int rb, output int fa);
        @(posedge clk); #1;
        tock          = 1'b1;
        tok_in_valid  = tv;
        tok_in_idx    = ti;
        tok_in_weight = tw;
        @(posedge clk); #1;
        tock          = 1'b0;
        tok_in_valid  = 1'b0;
        bc = 0; dn = 1'b0; rb = 0; fa = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                dn = done;
                break;
            end
            bc++;
            if (tok_in_ready) rb++;
            if (tok_out_valid && fa == 0) fa = bc;
        end
    endtask

    task automatic test_reset();
        int bc, rb, fa;
        bit dn;
        exp_q.delete(); obs_q.delete();
        rst_n = 1'b0;
        #3;
        n_tests++; if (tok_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", tok_out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_tests++; if (tok_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", tok_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_scan(1'b0, '0, '0, bc, dn, rb, fa);
        n_tests++; if (bc !== 8) begin n_fail++; $display("FAIL reset_busy_len: got %0d, expected 8", bc); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL reset_done_pulse: got %b, expected 1", dn); end
        n_tests++; if (fa !== 0) begin n_fail++; $display("FAIL reset_no_fire: first fire at %0d, expected none", fa); end
        n_tests++; if (rb !== 0) begin n_fail++; $display("FAIL reset_ready_in_emit: %0d cycles ready, expected 0", rb); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done_drop: got %b, expected 0", done); end
    endtask

    task automatic test_fire_clear();
        int bc, rb, fa, e, o;
        bit dn;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 3; i++) send_tok(3'd3, 4'sd7);
        exp_q.push_back(3);
        run_scan(1'b0, '0, '0, bc, dn, rb, fa);
        n_tests++; if (fa !== 4) begin n_fail++; $display("FAIL fire_cycle: got %0d, expected 4", fa); end
        n_tests++; if (bc !== 8) begin n_fail++; $display("FAIL fire_scan_len: got %0d, expected 8", bc); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fire_count: got %0d tokens, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL fire_idx: got %0d, expected %0d", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        run_scan(1'b0, '0, '0, bc, dn, rb, fa);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL clear_count: got %0d tokens, expected 0", obs_q.size()); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL clear_done: got %b, expected 1", dn); end
    endtask

    task automatic test_saturation();
        int bc, rb, fa, e, o;
        bit dn;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 20; i++) send_tok(3'd0, 4'sd7);
        for (int i = 0; i < 20; i++) send_tok(3'd1, -4'sd8);
        // A clamped 127 still meets a 127 threshold; a wrapped negative would not.
        cfg_write(3'd0, 8'sd127);
        // A clamped -128 stays below -127; a wrap to a positive value would fire.
        cfg_write(3'd1, -8'sd127);
        exp_q.push_back(0);
        run_scan(1'b0, '0, '0, bc, dn, rb, fa);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d tokens, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL sat_idx: got %0d, expected %0d", o, e); end
        end
        n_tests++; if (fa !== 1) begin n_fail++; $display("FAIL sat_fire_cycle: got %0d, expected 1", fa); end
    endtask

    task automatic test_backpressure();
        int bc, held, e, o;
        bit dn;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 3; i++) send_tok(3'd2, 4'sd7);
        for (int i = 0; i < 3; i++) send_tok(3'd5, 4'sd7);
        exp_q.push_back(2); exp_q.push_back(5);
        @(posedge clk); #1;
        tok_out_ready = 1'b0;
        tock = 1'b1;
        @(posedge clk); #1;
        tock = 1'b0;
        bc = 0; held = 0; dn = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                dn = done;
                break;
            end
            bc++;
            if (!tok_out_ready && (tok_out_valid || held > 0)) begin
                held++;
                n_tests++; if (tok_out_valid !== 1'b1 || tok_out_idx !== 3'd2) begin
                    n_fail++; $display("FAIL bp_hold: valid %b idx %0d, expected valid 1 idx 2", tok_out_valid, tok_out_idx);
                end
            end
            @(posedge clk); #1;
            if (held == 3) tok_out_ready = 1'b1;
        end
        tok_out_ready = 1'b1;
        n_tests++; if (held !== 3) begin n_fail++; $display("FAIL bp_held_cycles: got %0d, expected 3", held); end
        n_tests++; if (bc !== 11) begin n_fail++; $display("FAIL bp_scan_len: got %0d, expected 11", bc); end
        n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b, expected 1", dn); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d tokens, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL bp_idx: got %0d, expected %0d", o, e); end
        end
    endtask

    task automatic test_tock_with_token();
        int bc, rb, fa, e, o;
        bit dn;
        exp_q.delete(); obs_q.delete();
        cfg_write(3'd7, 8'sd5);
        exp_q.push_back(7);
        run_scan(1'b1, 3'd7, 4'sd7, bc, dn, rb, fa);
        n_tests++; if (fa !== 8) begin n_fail++; $display("FAIL tock_tok_cycle: got %0d, expected 8", fa); end
        n_tests++; if (rb !== 0) begin n_fail++; $display("FAIL emit_in_ready: %0d cycles ready, expected 0", rb); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tock_tok_count: got %0d tokens, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL tock_tok_idx: got %0d, expected %0d", o, e); end
        end
    endtask

    task automatic test_reset_midscan();
        int bc, rb, fa;
        bit dn, seen;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 3; i++) send_tok(3'd4, 4'sd7);
        @(posedge clk); #1;
        tok_out_ready = 1'b0;
        tock = 1'b1;
        @(posedge clk); #1;
        tock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (tok_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got valid %b, expected 1", seen); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (tok_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b, expected 0", tok_out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        n_tests++; if (tok_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b, expected 1", tok_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tok_out_ready = 1'b1;
        run_scan(1'b0, '0, '0, bc, dn, rb, fa);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_pots_cleared: got %0d tokens, expected 0", obs_q.size()); end
        n_tests++; if (bc !== 8) begin n_fail++; $display("FAIL mid_scan_len: got %0d, expected 8", bc); end
    endtask

    initial begin
        rst_n         = 1'b0;
        tok_in_valid  = 1'b0;
        tok_in_idx    = '0;
        tok_in_weight = '0;
        tock          = 1'b0;
        tok_out_ready = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_fire_clear();
        test_saturation();
        test_backpressure();
        test_tock_with_token();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
